obstacle_scheduler: RTL and testbench

Sequences the obstacle/bonus pattern ROM for the hero game. On every game step it picks a pseudo-random obstacle index with an 8-bit LFSR and forces a bonus index on a fixed spawn cadence. It drives the index to the registered ROM, waits out the ROM latency, and shifts the returned 7-segment pattern into a row of display lanes that scroll toward the hero digit. Downstream game logic reads the front lane and reports collisions back.

---
 rtl/obstacle_scheduler.sv | 162 ++++++++++++++++
 tb/tb_obstacle_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: steps the game, picks obstacle/bonus ROM indices from an
// 8-bit LFSR, waits out the registered ROM and scrolls patterns toward lane 0.
module obstacle_scheduler #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned STEP_CYCLES = 12_500_000,
  parameter int unsigned BONUS_EVERY = 8,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    collision,
  output logic [3:0]              obs_aleo,
  input  logic [6:0]              obstaculos,
  output logic [7*NUM_DIGITS-1:0] lanes,
  output logic [3:0]              front_code,
  output logic                    front_valid,
  output logic                    running,
  output logic                    game_over
);

  localparam int unsigned LANE_W  = 7;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned LANES_W = LANE_W * NUM_DIGITS;
  localparam int unsigned CODES_W = CODE_W * NUM_DIGITS;
  localparam int unsigned TIMER_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned SPAWN_W = (BONUS_EVERY > 1) ? $clog2(BONUS_EVERY) : 1;

  localparam logic [7:0]         SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [CODE_W-1:0]  BLANK      = 4'd13;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_CYCLES - 1);
  localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(BONUS_EVERY - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    FETCH  = 3'd2,
    SETTLE = 3'd3,
    OVER   = 3'd4
  } state_t;

  state_t               state;
  logic [7:0]           lfsr;
  logic [7:0]           lfsr_next;
  logic [TIMER_W-1:0]   timer;
  logic [SPAWN_W-1:0]   spawn_cnt;
  logic [CODES_W-1:0]   lane_codes;
  logic [CODE_W-1:0]    spawn_code;
  logic [LANES_W-1:0]   shifted_lanes;
  logic [CODES_W-1:0]   shifted_codes;

  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // ROM index for the upcoming spawn: bonus on cadence, else blank or digit
  always_comb begin
    spawn_code = BLANK;
    if (spawn_cnt == SPAWN_LAST) begin
      unique case (lfsr_next[1:0])
        2'd1:    spawn_code = 4'd11;
        2'd2:    spawn_code = 4'd12;
        default: spawn_code = 4'd10;
      endcase
    end else if (lfsr_next[7:6] == 2'b00) begin
      spawn_code = BLANK;
    end else if (lfsr_next[3:0] < 4'd10) begin
      spawn_code = lfsr_next[3:0];
    end else begin
      spawn_code = lfsr_next[3:0] - 4'd10;
    end
  end

  // Lanes after one scroll step: each lane takes its upper neighbour, spawn enters on top
  always_comb begin
    shifted_lanes = lanes;
    shifted_codes = lane_codes;
    for (int unsigned i = 0; i + 1 < NUM_DIGITS; i++) begin
      shifted_lanes[i*LANE_W +: LANE_W] = lanes[(i+1)*LANE_W +: LANE_W];
      shifted_codes[i*CODE_W +: CODE_W] = lane_codes[(i+1)*CODE_W +: CODE_W];
    end
    shifted_lanes[(NUM_DIGITS-1)*LANE_W +: LANE_W] = obstaculos;
    shifted_codes[(NUM_DIGITS-1)*CODE_W +: CODE_W] = obs_aleo;
  end

  // Game sequencer: step timer, spawn fetch, ROM wait, scroll; collision ends the game
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= SEED;
      timer       <= '0;
      spawn_cnt   <= '0;
      obs_aleo    <= BLANK;
      front_code  <= BLANK;
      lanes       <= '0;
      lane_codes  <= {NUM_DIGITS{BLANK}};
      front_valid <= 1'b0;
      running     <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      front_valid <= 1'b0;
      unique case (state)
        IDLE, OVER: begin
          if (start) begin
            state      <= RUN;
            running    <= 1'b1;
            game_over  <= 1'b0;
            timer      <= '0;
            spawn_cnt  <= '0;
            lanes      <= '0;
            lane_codes <= {NUM_DIGITS{BLANK}};
            front_code <= BLANK;
          end
        end
        RUN: begin
          if (collision) begin
            state     <= OVER;
            running   <= 1'b0;
            game_over <= 1'b1;
          end else if (!pause) begin
            if (timer == TIMER_LAST) begin
              state     <= FETCH;
              timer     <= '0;
              lfsr      <= lfsr_next;
              obs_aleo  <= spawn_code;
              spawn_cnt <= (spawn_cnt == SPAWN_LAST) ? '0 : spawn_cnt + SPAWN_W'(1);
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
        end
        FETCH: begin
          if (collision) begin
            state     <= OVER;
            running   <= 1'b0;
            game_over <= 1'b1;
          end else begin
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (collision) begin
            state     <= OVER;
            running   <= 1'b0;
            game_over <= 1'b1;
          end else begin
            state       <= RUN;
            lanes       <= shifted_lanes;
            lane_codes  <= shifted_codes;
            front_code  <= shifted_codes[CODE_W-1:0];
            front_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          running   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: behavioural game model plus a registered pattern ROM.
module tb_obstacle_scheduler;

  localparam int unsigned ND   = 4;
  localparam int unsigned SC   = 4;
  localparam int unsigned BE   = 8;
  localparam logic [7:0]  SEED = 8'hA5;

  logic            clk = 1'b0;
  logic            rst, start, pause, collision;
  logic [3:0]      obs_aleo;
  logic [6:0]      obstaculos;
  logic [7*ND-1:0] lanes;
  logic [3:0]      front_code;
  logic            front_valid, running, game_over;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model state
  logic [7:0] m_lfsr;
  int         m_spawn;
  int         m_obs;
  int         since_start;
  logic [6:0] m_pat [ND];
  int         m_code[ND];

  obstacle_scheduler #(
    .NUM_DIGITS (ND),
    .STEP_CYCLES(SC),
    .BONUS_EVERY(BE),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .collision  (collision),
    .obs_aleo   (obs_aleo),
    .obstaculos (obstaculos),
    .lanes      (lanes),
    .front_code (front_code),
    .front_valid(front_valid),
    .running    (running),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] rom_pat(input int c);
    case (c)
      0:       return 7'b0001111;
      5:       return 7'b0111111;
      13:      return 7'b0000000;
      default: return 7'(c * 9 + 3);
    endcase
  endfunction

  // Registered pattern ROM: one clock of latency
  always @(posedge clk) obstaculos <= rom_pat(int'(obs_aleo));

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int code_of(input logic [7:0] v, input bit bonus);
    if (bonus) return 10 + (int'(v[1:0]) % 3);
    if (v[7:6] == 2'b00) return 13;
    return int'(v[3:0]) % 10;
  endfunction

  function automatic logic [7*ND-1:0] exp_lanes();
    logic [7*ND-1:0] r;
    for (int i = 0; i < ND; i++) r[7*i +: 7] = m_pat[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < ND; i++) begin
      m_pat[i]  = 7'd0;
      m_code[i] = 13;
    end
    m_spawn     = 0;
    since_start = 0;
  endtask

  task automatic model_spawn();
    m_lfsr  = lfsr_step(m_lfsr);
    m_obs   = code_of(m_lfsr, m_spawn == BE - 1);
    m_spawn = (m_spawn + 1) % BE;
    since_start++;
  endtask

  task automatic model_shift();
    for (int i = 0; i + 1 < ND; i++) begin
      m_pat[i]  = m_pat[i+1];
      m_code[i] = m_code[i+1];
    end
    m_pat[ND-1]  = rom_pat(m_obs);
    m_code[ND-1] = m_obs;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_obs"},   obs_aleo, 13);
    check({tag, "_front"}, front_code, 13);
    check({tag, "_lanes"}, lanes, '0);
    check({tag, "_fv"},    front_valid, 0);
    check({tag, "_run"},   running, 0);
    check({tag, "_over"},  game_over, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    check("start_run",   running, 1);
    check("start_over",  game_over, 0);
    check("start_lanes", lanes, exp_lanes());
    check("start_front", front_code, 13);
  endtask

  // From the first RUN cycle (timer 0) up to the edge that enters FETCH
  task automatic run_to_fetch(input int p);
    tick();
    check("fv_low", front_valid, 0);
    if (p > 0) begin
      pause = 1'b1;
      repeat (p) tick();
      pause = 1'b0;
    end
    repeat (SC - 2) tick();
    check("obs_hold", obs_aleo, m_obs);
    check("running",  running, 1);
    tick();
    model_spawn();
    check("obs_new", obs_aleo, m_obs);
    check("bonus_cadence", (obs_aleo inside {[10:12]}), (since_start % BE == 0));
  endtask

  // FETCH -> SETTLE -> RUN with shift
  task automatic finish_step();
    tick();
    check("fv_settle", front_valid, 0);
    tick();
    model_shift();
    check("fv_pulse",   front_valid, 1);
    check("lanes",      lanes, exp_lanes());
    check("front_code", front_code, m_code[0]);
  endtask

  task automatic do_step(input int p);
    run_to_fetch(p);
    finish_step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; collision = 1'b0;
    m_lfsr = SEED; m_obs = 13;
    model_clear();
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    check("idle_run", running, 0);

    // Known A5 sequence: codes 0, 5, 13 and their patterns entering lane 3
    do_start();
    do_step(0);
    check("seq_obs0",  obs_aleo, 0);
    check("seq_lane0", lanes[7*ND-1 -: 7], 7'b0001111);
    do_step(0);
    check("seq_obs1",  obs_aleo, 5);
    check("seq_lane1", lanes[7*ND-1 -: 7], 7'b0111111);
    do_step(0);
    check("seq_obs2",  obs_aleo, 13);
    check("seq_lane2", lanes[7*ND-1 -: 7], 7'b0000000);
    do_step(0);
    check("scroll_lane0", lanes[6:0], 7'b0001111);
    check("scroll_front", front_code, 0);

    // Exact 10-cycle pause, then random steps through three bonus spawns
    do_step(10);
    for (int k = 0; k < 20; k++) begin
      do_step(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0);
    end

    // Collision during FETCH: drop the fetch, freeze lanes
    run_to_fetch(0);
    collision = 1'b1;
    tick();
    collision = 1'b0;
    check("col_over",  game_over, 1);
    check("col_run",   running, 0);
    check("col_lanes", lanes, exp_lanes());
    check("col_obs",   obs_aleo, m_obs);
    check("col_fv",    front_valid, 0);
    repeat (5) tick();
    check("over_hold_lanes", lanes, exp_lanes());
    check("over_hold_front", front_code, m_code[0]);
    check("over_hold_state", game_over, 1);

    // Restart keeps the LFSR running from where it stopped
    do_start();
    do_step(0);
    do_step($urandom_range(0, 6));

    // Collision during SETTLE: shift is dropped
    run_to_fetch(0);
    tick();
    collision = 1'b1;
    tick();
    collision = 1'b0;
    check("col2_over",  game_over, 1);
    check("col2_lanes", lanes, exp_lanes());
    check("col2_fv",    front_valid, 0);
    do_start();
    do_step(0);

    // Reset mid-SETTLE, then replay the seed sequence
    run_to_fetch(0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("rst_settle");
    m_lfsr = SEED; m_obs = 13;
    model_clear();
    do_start();
    do_step(0);
    check("replay_obs0", obs_aleo, 0);
    do_step(0);
    check("replay_obs1", obs_aleo, 5);
    do_step(0);
    check("replay_obs2", obs_aleo, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
